bola_aliada_ctrl: RTL and testbench
===================================

Name: bola_aliada_ctrl

Overview:
Upstream game-logic stage for the pixel renderer. It owns the player's shot ("bola aliada"): it launches the shot from the ship on a fire press and moves it upward once per video frame. It detects hits on the enemy rectangle, counts points, and drives the renderer's x_bola_aliada / y_bola_aliada / raio_bola_aliada inputs in screen coordinates. All ship and enemy positions are game coordinates; screen = game + (OFFSET_X, OFFSET_Y).

Parameters:
RAIO, 5, shot radius in pixels while in flight
VELOCIDADE, 4, upward pixels moved per frame_tick
OFFSET_X, 144, game-to-screen X offset (matches renderer)
OFFSET_Y, 35, game-to-screen Y offset and top visible line
ESPERA, 8, cooldown length in frame_ticks after hit or exit

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-high
ativo  in  1  game running
perdeu  in  1  game lost
disparo  in  1  fire button, synchronised level, active-high
frame_tick  in  1  one-cycle pulse per frame, from VGA sync at vblank start
x_nave, y_nave  in  10 each  ship top-left, game coordinates
largura_nave  in  10  ship width
x_inimigo, y_inimigo  in  10 each  enemy top-left, game coordinates
largura_inimigo, altura_inimigo  in  10 each  enemy size
x_bola_aliada, y_bola_aliada  out  10 each  shot centre, screen coordinates
raio_bola_aliada  out  10  RAIO in flight, else 0 (renderer draws nothing)
em_voo  out  1  shot in flight
acerto  out  1  one-cycle hit pulse
pontos  out  8  hit counter, saturating

Behaviour:
- Reset values: state OCIOSO; x, y, raio, em_voo, acerto, pontos, cooldown counter and disparo_prev all 0. All outputs are registered.
- Rising-edge detect on disparo: the edge is disparo & ~disparo_prev. Held buttons fire once.
- Internal sums are 11 bits wide; outputs are truncated to 10 bits. Ship centre uses largura_nave>>1.
- OCIOSO:
  - On a disparo edge with ativo & ~perdeu, go to VOO at the next edge.
  - On launch: x = x_nave+OFFSET_X+(largura_nave>>1); y = y_nave+OFFSET_Y-RAIO; raio = RAIO; em_voo = 1.
  - A frame_tick in the launch cycle does not move the shot.
- VOO, evaluated only on frame_tick, using the current position, in priority order:
  1. Hit: x in [x_inimigo+OFFSET_X, x_inimigo+OFFSET_X+largura_inimigo], and y-RAIO <= y_inimigo+OFFSET_Y+altura_inimigo, and y+RAIO >= y_inimigo+OFFSET_Y. Result: acerto = 1 for exactly one cycle; pontos += 1, saturating at 255; go to ESPERA.
  2. Exit: y < OFFSET_Y+RAIO+VELOCIDADE. Go to ESPERA.
  3. Otherwise: y -= VELOCIDADE; x unchanged, so the ship moving does not steer the shot.
  - Hit has priority when hit and exit coincide.
- ESPERA:
  - On entry: raio = 0, em_voo = 0, counter = 0.
  - The counter increments on each frame_tick. When it reaches ESPERA, go to OCIOSO.
  - disparo edges are ignored; an edge in the exit cycle does not queue.
- Abort (synchronous): ~ativo or perdeu in any state forces OCIOSO at the next edge with raio = 0, em_voo = 0, counter cleared, and no acerto.
  - ~ativo additionally clears pontos.
  - perdeu holds pontos.
- x/y hold their last values when not in flight; only raio gates visibility.

Decomposition:
- Shared package jogo_pkg:
  - state encoding (OCIOSO/VOO/ESPERA)
  - OFFSET_X/OFFSET_Y constants, shared with the renderer
  - coordinate width (10)
- Sub-module colisao_ret: combinational test of circle bounding box against rectangle, 11-bit internal. Reused later for the enemy shot against the ship.

Test Plan:
1. x_nave=100, y_nave=400, largura_nave=40, disparo rises → next cycle x=264, y=430, raio=5, em_voo=1; one frame_tick → y=426; holding disparo launches nothing more.
2. Same launch, enemy at (110,100) 40x20 (screen 254..294, 135..155) → 68 ticks move the shot to y=158; the 69th tick pulses acerto for one cycle, pontos=1, raio=0.
3. Same launch, enemy at x=400 → after 97 ticks y=42; the 98th tick exits with raio=0 and no acerto; 8 further ticks return to OCIOSO; disparo during ESPERA is ignored.
4. perdeu asserted mid-flight at y=300 → next cycle raio=0, em_voo=0, pontos unchanged; ativo=0 → pontos=0.
5. After 255 hits, a 256th hit → acerto pulses, pontos stays 255.
6. reset asserted mid-flight, asynchronous → all outputs 0 immediately; a later disparo edge launches normally.

Source files
------------

// File: rtl/jogo_pkg.sv
// Constants and types shared by the game-logic stages and the pixel renderer.
package jogo_pkg;

  localparam int unsigned LARGURA_COORD = 10;
  localparam int unsigned JOGO_OFFSET_X = 144;
  localparam int unsigned JOGO_OFFSET_Y = 35;

  typedef logic [LARGURA_COORD-1:0] coord_t;
  typedef logic [LARGURA_COORD:0]   soma_t;

  typedef enum logic [1:0] {
    StOcioso,
    StVoo,
    StEspera
  } estado_t;

endpackage

// File: rtl/bola_aliada_ctrl_if.sv
// Game-side inputs and renderer-side outputs of the player's shot controller.
interface bola_aliada_ctrl_if;
  import jogo_pkg::*;

  logic   ativo;
  logic   perdeu;
  logic   disparo;
  logic   frame_tick;
  coord_t x_nave;
  coord_t y_nave;
  coord_t largura_nave;
  coord_t x_inimigo;
  coord_t y_inimigo;
  coord_t largura_inimigo;
  coord_t altura_inimigo;
  coord_t x_bola_aliada;
  coord_t y_bola_aliada;
  coord_t raio_bola_aliada;
  logic   em_voo;
  logic   acerto;
  logic [7:0] pontos;

  modport master (
    output ativo, perdeu, disparo, frame_tick,
    output x_nave, y_nave, largura_nave,
    output x_inimigo, y_inimigo, largura_inimigo, altura_inimigo,
    input  x_bola_aliada, y_bola_aliada, raio_bola_aliada, em_voo, acerto, pontos
  );

  modport slave (
    input  ativo, perdeu, disparo, frame_tick,
    input  x_nave, y_nave, largura_nave,
    input  x_inimigo, y_inimigo, largura_inimigo, altura_inimigo,
    output x_bola_aliada, y_bola_aliada, raio_bola_aliada, em_voo, acerto, pontos
  );

endinterface

// File: rtl/colisao_ret.sv
// Combinational hit test: circle centre column inside the rectangle span and the
// circle's vertical extent overlapping it. All quantities in screen coordinates.
module colisao_ret
  import jogo_pkg::*;
(
  input  soma_t  i_cx,
  input  soma_t  i_cy,
  input  soma_t  i_raio,
  input  soma_t  i_ret_x,
  input  soma_t  i_ret_y,
  input  coord_t i_largura,
  input  coord_t i_altura,
  output logic   o_colide
);

  soma_t w_dir;
  soma_t w_base;
  soma_t w_topo_bola;
  soma_t w_base_bola;

  assign w_dir       = i_ret_x + {1'b0, i_largura};
  assign w_base      = i_ret_y + {1'b0, i_altura};
  assign w_topo_bola = i_cy - i_raio;
  assign w_base_bola = i_cy + i_raio;

  assign o_colide = (i_cx >= i_ret_x) && (i_cx <= w_dir) &&
                    (w_topo_bola <= w_base) && (w_base_bola >= i_ret_y);

endmodule

// File: rtl/bola_aliada_ctrl.sv
// Player's shot: launch from the ship on a fire edge, climb once per frame,
// score hits on the enemy, then cool down before the next shot.
module bola_aliada_ctrl
  import jogo_pkg::*;
#(
    parameter int unsigned RAIO       = 5,
    parameter int unsigned VELOCIDADE = 4,
    parameter int unsigned OFFSET_X   = JOGO_OFFSET_X,
    parameter int unsigned OFFSET_Y   = JOGO_OFFSET_Y,
    parameter int unsigned ESPERA     = 8
) (
    input logic               CLOCK_50,
    input logic               reset,
    bola_aliada_ctrl_if.slave bus
);

    localparam int unsigned LARG_CONT = $clog2(ESPERA + 1);
    localparam soma_t  OFF_X_W   = soma_t'(OFFSET_X);
    localparam soma_t  OFF_Y_W   = soma_t'(OFFSET_Y);
    localparam soma_t  RAIO_W    = soma_t'(RAIO);
    localparam soma_t  LIM_SAIDA = soma_t'(OFFSET_Y + RAIO + VELOCIDADE);
    localparam coord_t RAIO_C    = coord_t'(RAIO);
    localparam coord_t VEL_C     = coord_t'(VELOCIDADE);
    localparam logic [LARG_CONT-1:0] CONT_FIM = LARG_CONT'(ESPERA - 1);

    estado_t              r_estado, r_estado_d;
    coord_t               r_x, r_x_d;
    coord_t               r_y, r_y_d;
    coord_t               r_raio, r_raio_d;
    logic                 r_em_voo, r_em_voo_d;
    logic                 r_acerto, r_acerto_d;
    logic [7:0]           r_pontos, r_pontos_d;
    logic [LARG_CONT-1:0] r_cont, r_cont_d;
    logic                 r_disparo_prev;

    logic w_borda;
    logic w_colide;

    assign w_borda = bus.disparo & ~r_disparo_prev;

    colisao_ret u_colisao (
        .i_cx      ({1'b0, r_x}),
        .i_cy      ({1'b0, r_y}),
        .i_raio    (RAIO_W),
        .i_ret_x   ({1'b0, bus.x_inimigo} + OFF_X_W),
        .i_ret_y   ({1'b0, bus.y_inimigo} + OFF_Y_W),
        .i_largura (bus.largura_inimigo),
        .i_altura  (bus.altura_inimigo),
        .o_colide  (w_colide)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_estado       <= StOcioso;
            r_x            <= '0;
            r_y            <= '0;
            r_raio         <= '0;
            r_em_voo       <= 1'b0;
            r_acerto       <= 1'b0;
            r_pontos       <= '0;
            r_cont         <= '0;
            r_disparo_prev <= 1'b0;
        end else begin
            r_estado       <= r_estado_d;
            r_x            <= r_x_d;
            r_y            <= r_y_d;
            r_raio         <= r_raio_d;
            r_em_voo       <= r_em_voo_d;
            r_acerto       <= r_acerto_d;
            r_pontos       <= r_pontos_d;
            r_cont         <= r_cont_d;
            r_disparo_prev <= bus.disparo;
        end
    end

    always_comb begin
        r_estado_d = r_estado;
        r_x_d      = r_x;
        r_y_d      = r_y;
        r_raio_d   = r_raio;
        r_em_voo_d = r_em_voo;
        r_acerto_d = 1'b0;
        r_pontos_d = r_pontos;
        r_cont_d   = r_cont;

        // Abort outranks everything; x/y are left as they were.
        if (!bus.ativo || bus.perdeu) begin
            r_estado_d = StOcioso;
            r_raio_d   = '0;
            r_em_voo_d = 1'b0;
            r_cont_d   = '0;
            if (!bus.ativo) r_pontos_d = '0;
        end else begin
            unique case (r_estado)
                StOcioso: begin
                    if (w_borda) begin
                        r_estado_d = StVoo;
                        r_x_d      = coord_t'({1'b0, bus.x_nave} + OFF_X_W +
                                              ({1'b0, bus.largura_nave} >> 1));
                        r_y_d      = coord_t'({1'b0, bus.y_nave} + OFF_Y_W - RAIO_W);
                        r_raio_d   = RAIO_C;
                        r_em_voo_d = 1'b1;
                    end
                end
                StVoo: begin
                    if (bus.frame_tick) begin
                        if (w_colide || ({1'b0, r_y} < LIM_SAIDA)) begin
                            r_estado_d = StEspera;
                            r_raio_d   = '0;
                            r_em_voo_d = 1'b0;
                            r_cont_d   = '0;
                            if (w_colide) begin
                                r_acerto_d = 1'b1;
                                if (r_pontos != 8'hFF) r_pontos_d = r_pontos + 8'd1;
                            end
                        end else begin
                            r_y_d = r_y - VEL_C;
                        end
                    end
                end
                StEspera: begin
                    if (bus.frame_tick) begin
                        r_cont_d = r_cont + 1'b1;
                        if (r_cont == CONT_FIM) r_estado_d = StOcioso;
                    end
                end
                default: r_estado_d = StOcioso;
            endcase
        end
    end

    assign bus.x_bola_aliada    = r_x;
    assign bus.y_bola_aliada    = r_y;
    assign bus.raio_bola_aliada = r_raio;
    assign bus.em_voo           = r_em_voo;
    assign bus.acerto           = r_acerto;
    assign bus.pontos           = r_pontos;

endmodule

// File: tb/tb_bola_aliada_ctrl.sv
// Directed bench for bola_aliada_ctrl: launch, hit, exit/cooldown, abort,
// score saturation and asynchronous reset.
module tb_bola_aliada_ctrl;
    import jogo_pkg::*;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    bola_aliada_ctrl_if u_if ();

    bola_aliada_ctrl #(
        .RAIO       (5),
        .VELOCIDADE (4),
        .OFFSET_X   (144),
        .OFFSET_Y   (35),
        .ESPERA     (8)
    ) u_dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (u_if)
    );

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic frames(input int n);
        u_if.frame_tick = 1'b1;
        step(n);
        u_if.frame_tick = 1'b0;
    endtask

    task automatic fire();
        u_if.disparo = 1'b1;
        step();
        u_if.disparo = 1'b0;
    endtask

    task automatic set_ship(input int x, input int y);
        u_if.x_nave       = 10'(x);
        u_if.y_nave       = 10'(y);
        u_if.largura_nave = 10'd40;
    endtask

    task automatic set_enemy(input int x, input int y);
        u_if.x_inimigo       = 10'(x);
        u_if.y_inimigo       = 10'(y);
        u_if.largura_inimigo = 10'd40;
        u_if.altura_inimigo  = 10'd20;
    endtask

    task automatic test_reset();
        n_checks += 6;
        if (u_if.x_bola_aliada !== 10'd0) begin
            n_errors++; $display("FAIL reset_x got %0d want 0", u_if.x_bola_aliada);
        end
        if (u_if.y_bola_aliada !== 10'd0) begin
            n_errors++; $display("FAIL reset_y got %0d want 0", u_if.y_bola_aliada);
        end
        if (u_if.raio_bola_aliada !== 10'd0) begin
            n_errors++; $display("FAIL reset_raio got %0d want 0", u_if.raio_bola_aliada);
        end
        if (u_if.em_voo !== 1'b0) begin
            n_errors++; $display("FAIL reset_em_voo got %b want 0", u_if.em_voo);
        end
        if (u_if.acerto !== 1'b0) begin
            n_errors++; $display("FAIL reset_acerto got %b want 0", u_if.acerto);
        end
        if (u_if.pontos !== 8'd0) begin
            n_errors++; $display("FAIL reset_pontos got %0d want 0", u_if.pontos);
        end
    endtask

    task automatic test_launch();
        set_ship(100, 400);
        set_enemy(400, 100);
        u_if.disparo    = 1'b1;
        u_if.frame_tick = 1'b1;
        step();
        n_checks += 4;
        if (u_if.x_bola_aliada !== 10'd264) begin
            n_errors++; $display("FAIL launch_x got %0d want 264", u_if.x_bola_aliada);
        end
        if (u_if.y_bola_aliada !== 10'd430) begin
            n_errors++; $display("FAIL launch_y got %0d want 430", u_if.y_bola_aliada);
        end
        if (u_if.raio_bola_aliada !== 10'd5) begin
            n_errors++; $display("FAIL launch_raio got %0d want 5", u_if.raio_bola_aliada);
        end
        if (u_if.em_voo !== 1'b1) begin
            n_errors++; $display("FAIL launch_em_voo got %b want 1", u_if.em_voo);
        end
        step();
        u_if.frame_tick = 1'b0;
        n_checks++;
        if (u_if.y_bola_aliada !== 10'd426) begin
            n_errors++; $display("FAIL first_move_y got %0d want 426", u_if.y_bola_aliada);
        end
        u_if.perdeu = 1'b1;
        step();
        u_if.perdeu = 1'b0;
        step(3);
        n_checks++;
        if (u_if.em_voo !== 1'b0) begin
            n_errors++; $display("FAIL held_fire_em_voo got %b want 0", u_if.em_voo);
        end
        u_if.disparo = 1'b0;
        step();
    endtask

    task automatic test_hit();
        set_ship(100, 400);
        set_enemy(110, 100);
        fire();
        frames(68);
        n_checks += 2;
        if (u_if.y_bola_aliada !== 10'd158) begin
            n_errors++; $display("FAIL hit_pre_y got %0d want 158", u_if.y_bola_aliada);
        end
        if (u_if.acerto !== 1'b0) begin
            n_errors++; $display("FAIL hit_pre_acerto got %b want 0", u_if.acerto);
        end
        frames(1);
        n_checks += 4;
        if (u_if.acerto !== 1'b1) begin
            n_errors++; $display("FAIL hit_acerto got %b want 1", u_if.acerto);
        end
        if (u_if.pontos !== 8'd1) begin
            n_errors++; $display("FAIL hit_pontos got %0d want 1", u_if.pontos);
        end
        if (u_if.raio_bola_aliada !== 10'd0) begin
            n_errors++; $display("FAIL hit_raio got %0d want 0", u_if.raio_bola_aliada);
        end
        if (u_if.em_voo !== 1'b0) begin
            n_errors++; $display("FAIL hit_em_voo got %b want 0", u_if.em_voo);
        end
        step();
        n_checks++;
        if (u_if.acerto !== 1'b0) begin
            n_errors++; $display("FAIL hit_pulse_width got %b want 0", u_if.acerto);
        end
        frames(8);
    endtask

    task automatic test_exit_cooldown();
        set_ship(100, 400);
        set_enemy(400, 100);
        fire();
        frames(97);
        n_checks++;
        if (u_if.y_bola_aliada !== 10'd42) begin
            n_errors++; $display("FAIL exit_pre_y got %0d want 42", u_if.y_bola_aliada);
        end
        frames(1);
        n_checks += 3;
        if (u_if.raio_bola_aliada !== 10'd0) begin
            n_errors++; $display("FAIL exit_raio got %0d want 0", u_if.raio_bola_aliada);
        end
        if (u_if.acerto !== 1'b0) begin
            n_errors++; $display("FAIL exit_acerto got %b want 0", u_if.acerto);
        end
        if (u_if.pontos !== 8'd1) begin
            n_errors++; $display("FAIL exit_pontos got %0d want 1", u_if.pontos);
        end
        frames(7);
        fire();
        step();
        frames(1);
        step(2);
        n_checks++;
        if (u_if.em_voo !== 1'b0) begin
            n_errors++; $display("FAIL cooldown_ignore got %b want 0", u_if.em_voo);
        end
        fire();
        n_checks++;
        if (u_if.em_voo !== 1'b1) begin
            n_errors++; $display("FAIL relaunch_em_voo got %b want 1", u_if.em_voo);
        end
        u_if.perdeu = 1'b1;
        step();
        u_if.perdeu = 1'b0;
        step();
    endtask

    task automatic test_abort();
        set_ship(100, 402);
        set_enemy(400, 100);
        fire();
        frames(33);
        n_checks++;
        if (u_if.y_bola_aliada !== 10'd300) begin
            n_errors++; $display("FAIL abort_pre_y got %0d want 300", u_if.y_bola_aliada);
        end
        u_if.perdeu = 1'b1;
        step();
        u_if.perdeu = 1'b0;
        n_checks += 4;
        if (u_if.raio_bola_aliada !== 10'd0) begin
            n_errors++; $display("FAIL perdeu_raio got %0d want 0", u_if.raio_bola_aliada);
        end
        if (u_if.em_voo !== 1'b0) begin
            n_errors++; $display("FAIL perdeu_em_voo got %b want 0", u_if.em_voo);
        end
        if (u_if.pontos !== 8'd1) begin
            n_errors++; $display("FAIL perdeu_pontos got %0d want 1", u_if.pontos);
        end
        if (u_if.y_bola_aliada !== 10'd300) begin
            n_errors++; $display("FAIL perdeu_y_hold got %0d want 300", u_if.y_bola_aliada);
        end
        u_if.ativo = 1'b0;
        step();
        u_if.ativo = 1'b1;
        n_checks++;
        if (u_if.pontos !== 8'd0) begin
            n_errors++; $display("FAIL inativo_pontos got %0d want 0", u_if.pontos);
        end
        step();
    endtask

    // Shot launched at y=40 sits both inside the enemy and below the exit line.
    task automatic test_hit_exit_priority();
        set_ship(100, 10);
        set_enemy(110, 0);
        fire();
        n_checks++;
        if (u_if.y_bola_aliada !== 10'd40) begin
            n_errors++; $display("FAIL prio_launch_y got %0d want 40", u_if.y_bola_aliada);
        end
        frames(1);
        n_checks += 2;
        if (u_if.acerto !== 1'b1) begin
            n_errors++; $display("FAIL prio_acerto got %b want 1", u_if.acerto);
        end
        if (u_if.pontos !== 8'd1) begin
            n_errors++; $display("FAIL prio_pontos got %0d want 1", u_if.pontos);
        end
        frames(8);
    endtask

    task automatic test_saturation();
        set_ship(100, 400);
        set_enemy(110, 390);
        for (int i = 0; i < 254; i++) begin
            fire();
            frames(1);
            frames(8);
        end
        n_checks++;
        if (u_if.pontos !== 8'd255) begin
            n_errors++; $display("FAIL sat_reach got %0d want 255", u_if.pontos);
        end
        fire();
        frames(1);
        n_checks += 2;
        if (u_if.acerto !== 1'b1) begin
            n_errors++; $display("FAIL sat_acerto got %b want 1", u_if.acerto);
        end
        if (u_if.pontos !== 8'd255) begin
            n_errors++; $display("FAIL sat_pontos got %0d want 255", u_if.pontos);
        end
        frames(8);
    endtask

    task automatic test_async_reset();
        set_ship(100, 400);
        set_enemy(400, 100);
        fire();
        frames(3);
        #3;
        reset = 1'b1;
        #1;
        n_checks += 4;
        if (u_if.raio_bola_aliada !== 10'd0 || u_if.em_voo !== 1'b0) begin
            n_errors++;
            $display("FAIL areset_flight got raio=%0d em_voo=%b want 0/0",
                     u_if.raio_bola_aliada, u_if.em_voo);
        end
        if (u_if.x_bola_aliada !== 10'd0 || u_if.y_bola_aliada !== 10'd0) begin
            n_errors++;
            $display("FAIL areset_xy got %0d,%0d want 0,0", u_if.x_bola_aliada,
                     u_if.y_bola_aliada);
        end
        if (u_if.pontos !== 8'd0) begin
            n_errors++; $display("FAIL areset_pontos got %0d want 0", u_if.pontos);
        end
        if (u_if.acerto !== 1'b0) begin
            n_errors++; $display("FAIL areset_acerto got %b want 0", u_if.acerto);
        end
        #1;
        reset = 1'b0;
        step(2);
        fire();
        n_checks += 2;
        if (u_if.em_voo !== 1'b1 || u_if.y_bola_aliada !== 10'd430) begin
            n_errors++;
            $display("FAIL post_reset_launch got em_voo=%b y=%0d want 1/430", u_if.em_voo,
                     u_if.y_bola_aliada);
        end
        if (u_if.x_bola_aliada !== 10'd264) begin
            n_errors++; $display("FAIL post_reset_x got %0d want 264", u_if.x_bola_aliada);
        end
    endtask

    initial begin
        u_if.ativo      = 1'b1;
        u_if.perdeu     = 1'b0;
        u_if.disparo    = 1'b0;
        u_if.frame_tick = 1'b0;
        set_ship(100, 400);
        set_enemy(400, 100);
        #12;
        test_reset();
        reset = 1'b0;
        step();
        test_launch();
        test_hit();
        test_exit_cooldown();
        test_abort();
        test_hit_exit_priority();
        test_saturation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
